nibble_serial_add_seq: RTL and testbench

//  Sequencer that computes WIDTH-bit sums (A + B + cin) on one shared 4-bit

---
 rtl/nibble_serial_add_seq.sv | 134 +++++++++++++
 tb/tb_nibble_serial_add_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_seq.sv
// Sequencer computing WIDTH-bit A+B+cin on an external 4-bit adder slice,
// one nibble per SUM/CARRY step pair, with valid/ready on both sides.
module nibble_serial_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  input  logic [3:0]       add_s,
  input  logic             add_co
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, SUM, CARRY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] res_q, res_nxt;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic             carry_q, carry_nxt;
  logic             c1_q, c1_nxt;
  logic             req_ready_nxt, rsp_valid_nxt, rsp_cout_nxt;
  logic [WIDTH-1:0] rsp_sum_nxt;
  logic [3:0]       add_x_nxt, add_y_nxt;

  // Select nibble i of a latched operand.
  function automatic logic [3:0] nib(input logic [WIDTH-1:0] v, input int unsigned i);
    return v[4*i +: 4];
  endfunction

  // State and registered outputs; add_x doubles as the partial-sum register in CARRY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      c1_q      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      add_x     <= 4'h0;
      add_y     <= 4'h0;
    end else begin
      state     <= state_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      res_q     <= res_nxt;
      idx_q     <= idx_nxt;
      carry_q   <= carry_nxt;
      c1_q      <= c1_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_sum   <= rsp_sum_nxt;
      rsp_cout  <= rsp_cout_nxt;
      add_x     <= add_x_nxt;
      add_y     <= add_y_nxt;
    end
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_nxt    = state;
    a_nxt        = a_q;
    b_nxt        = b_q;
    res_nxt      = res_q;
    idx_nxt      = idx_q;
    carry_nxt    = carry_q;
    c1_nxt       = c1_q;
    rsp_sum_nxt  = rsp_sum;
    rsp_cout_nxt = rsp_cout;
    add_x_nxt    = 4'h0;
    add_y_nxt    = 4'h0;

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          a_nxt     = op_a;
          b_nxt     = op_b;
          carry_nxt = cin;
          idx_nxt   = '0;
          add_x_nxt = op_a[3:0];
          add_y_nxt = op_b[3:0];
          state_nxt = SUM;
        end
      end
      SUM: begin
        c1_nxt    = add_co;
        add_x_nxt = add_s;
        add_y_nxt = {3'b000, carry_q};
        state_nxt = CARRY;
      end
      CARRY: begin
        res_nxt[4*int'(idx_q) +: 4] = add_s;
        // c1 and add_co are mutually exclusive, so OR is the exact carry.
        carry_nxt = c1_q | add_co;
        if (idx_q == IW'(NIB - 1)) begin
          rsp_sum_nxt  = res_nxt;
          rsp_cout_nxt = carry_nxt;
          state_nxt    = DONE;
        end else begin
          idx_nxt   = idx_q + IW'(1);
          add_x_nxt = nib(a_q, int'(idx_q) + 1);
          add_y_nxt = nib(b_q, int'(idx_q) + 1);
          state_nxt = SUM;
        end
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    req_ready_nxt = (state_nxt == IDLE);
    rsp_valid_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Randomised and directed bench for nibble_serial_add_seq (WIDTH=16 and WIDTH=4).
module tb_nibble_serial_add_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 16-bit instance signals
  logic        req_valid, req_ready, cin, rsp_valid, rsp_ready, rsp_cout, add_co;
  logic [15:0] op_a, op_b, rsp_sum;
  logic [3:0]  add_x, add_y, add_s;

  // 4-bit instance signals
  logic        req_valid4, req_ready4, cin4, rsp_valid4, rsp_ready4, rsp_cout4, add_co4;
  logic [3:0]  op_a4, op_b4, rsp_sum4;
  logic [3:0]  add_x4, add_y4, add_s4;

  // Behavioural 4-bit ripple adder slices
  assign {add_co, add_s}   = {1'b0, add_x} + {1'b0, add_y};
  assign {add_co4, add_s4} = {1'b0, add_x4} + {1'b0, add_y4};

  nibble_serial_add_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_x(add_x), .add_y(add_y), .add_s(add_s), .add_co(add_co)
  );

  nibble_serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .op_a(op_a4), .op_b(op_b4), .cin(cin4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_sum(rsp_sum4), .rsp_cout(rsp_cout4),
    .add_x(add_x4), .add_y(add_y4), .add_s(add_s4), .add_co(add_co4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic logic [16:0] ref16(input logic [15:0] a, b, input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  // Issue one request and wait for rsp_valid; lat counts cycles after the accept edge.
  task automatic req16(input logic [15:0] a, b, input logic c, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 40) begin @(negedge clk); w++; end
    req_valid = 1'b1; op_a = a; op_b = b; cin = c;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic ack16();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, b, input logic c);
    int lat;
    logic [16:0] e;
    e = ref16(a, b, c);
    req16(a, b, c, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_res"}, {15'd0, rsp_cout, rsp_sum}, {15'd0, e});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {18'd0, rsp_valid, req_ready, rsp_cout, add_x, add_y} , {18'd0, 1'b0, 1'b1, 1'b0, 8'h00});
    chk({tag, "_sum"}, 32'(rsp_sum), 32'd0);
  endtask

  // Watch rsp_valid for n cycles; flags any spurious response.
  task automatic quiet16(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin @(negedge clk); seen |= rsp_valid; end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] e;
    int          lat, dly, w;
    logic [4:0]  e4;

    reset_n = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    req_valid4 = 1'b0; rsp_ready4 = 1'b0; op_a4 = '0; op_b4 = '0; cin4 = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("reset_init");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Basic sum, then async reset while holding the response in DONE
    op16("t2", 16'h1234, 16'h4321, 1'b0);
    chk("t2_sum", 32'(rsp_sum), 32'h5555);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    reset_n = 1'b1;

    op16("t3", 16'hFFFF, 16'h0001, 1'b0);
    chk("t3_res", {15'd0, rsp_cout, rsp_sum}, 32'h10000);
    ack16();
    op16("t4a", 16'h000F, 16'h0000, 1'b1);
    chk("t4a_res", {15'd0, rsp_cout, rsp_sum}, 32'h00010);
    ack16();
    op16("t4b", 16'hFFFF, 16'hFFFF, 1'b1);
    chk("t4b_res", {15'd0, rsp_cout, rsp_sum}, 32'h1FFFF);
    ack16();

    // Back-pressure: response held stable, requests ignored
    op16("t5", 16'hA5A5, 16'h1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin req_valid = 1'b1; op_a = 16'h0001; op_b = 16'h0001; end
      if (i == 3) req_valid = 1'b0;
      @(negedge clk);
      chk("t5_hold", {13'd0, rsp_valid, req_ready, rsp_cout, rsp_sum}, {13'd0, 1'b1, 1'b0, 17'h0B6B7});
    end
    req_valid = 1'b0;
    ack16();
    chk("t5_idle", 32'(req_ready), 32'd1);
    quiet16("t5_no_accept", 12);

    // Reset in the 3rd cycle after accept drops the op
    @(negedge clk);
    req_valid = 1'b1; op_a = 16'h1357; op_b = 16'h2468; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1 chk_reset_vals("t6_reset");
    @(negedge clk);
    reset_n = 1'b1;
    quiet16("t6_dropped", 12);
    op16("t6", 16'h0F0F, 16'hF0F1, 1'b0);
    chk("t6_res", {15'd0, rsp_cout, rsp_sum}, 32'h10000);
    ack16();

    // Random operands with random response back-pressure
    for (int n = 0; n < 60; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      op16("rand", ra, rb, rc);
      e = ref16(ra, rb, rc);
      dly = int'($urandom_range(0, 3));
      for (int k = 0; k < dly; k++) @(negedge clk);
      chk("rand_hold", {15'd0, rsp_cout, rsp_sum}, {15'd0, e});
      ack16();
    end

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          e4 = 5'(a) + 5'(b) + 5'(c);
          @(negedge clk);
          req_valid4 = 1'b1; op_a4 = 4'(a); op_b4 = 4'(b); cin4 = 1'(c);
          @(posedge clk);
          @(negedge clk);
          req_valid4 = 1'b0;
          lat = 1; w = 0;
          while (!rsp_valid4 && lat < 20) begin @(negedge clk); lat++; end
          chk("w4_lat", 32'(lat), 32'd3);
          chk("w4_res", {27'd0, rsp_cout4, rsp_sum4}, {27'd0, e4});
          rsp_ready4 = 1'b1;
          @(negedge clk);
          rsp_ready4 = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
